jls_golomb_packer: RTL

Parametrised Golomb-Rice encoder with integrated bit packer for the JPEG-LS datapath. It sits after the modulo-reduction/mapping stage and after the run-mode logic. It accepts one symbol per handshake: a regular Golomb symbol, a raw run-mode bit field, or a flush request. It produces MSB-first packed words of `OUT_W` bits, with `LIMIT`/`qbpp` escape coding and full valid/ready backpressure on both sides.

---
 rtl/jls_pkg.sv | 27 ++
 rtl/jls_bit_accumulator.sv | 80 ++++++++
 rtl/jls_golomb_packer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/jls_pkg.sv
// Shared types for the JPEG-LS Golomb-Rice encoder and bit packer.
// Symbol type codes, FSM states and the escape threshold helper.
package jls_pkg;

  localparam logic [1:0] T_GOLOMB = 2'd0;
  localparam logic [1:0] T_RAW    = 2'd1;
  localparam logic [1:0] T_FLUSH  = 2'd2;
  localparam logic [1:0] T_NOP    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ZEROS,
    S_TAIL,
    S_FLUSH
  } jls_state_e;

  // Unary prefix length at which escape coding kicks in:
  // glimit - qbpp - 1, with glimit = limit - adj.
  function automatic int jls_thr(
    input int          limit,
    input int          qbpp,
    input logic [5:0]  adj
  );
    return limit - int'(adj) - qbpp - 1;
  endfunction

endpackage

// File: rtl/jls_bit_accumulator.sv
// MSB-first bit accumulator: appends fields below the fill point and
// emits OUT_W-bit words with a valid/ready handshake.
module jls_bit_accumulator #(
  parameter int OUT_W = 32,
  parameter int LEN_W = $clog2(OUT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             app_en,
  input  logic [OUT_W-1:0] app_val,
  input  logic [LEN_W-1:0] app_len,
  input  logic             pad,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_word,
  output logic             out_last,
  output logic             room,
  output logic             empty
);

  localparam int ACC_W = 2 * OUT_W;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam logic [CNT_W-1:0] WC  = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] WC2 = CNT_W'(ACC_W);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_n;
  logic [ACC_W-1:0] base_acc;
  logic [ACC_W-1:0] ins;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] eff;
  logic [CNT_W-1:0] base_cnt;
  logic             hs;
  logic             do_app;

  // Bits below cnt are always zero, so padding only moves the count.
  always_comb begin
    eff = cnt;
    if (pad) begin
      if (cnt > WC)
        eff = WC2;
      else if (cnt != '0)
        eff = WC;
    end
  end

  assign out_valid = (eff >= WC);
  assign out_word  = acc[ACC_W-1 -: OUT_W];
  assign out_last  = pad & (eff == WC);
  assign hs        = out_valid & out_ready;
  assign room      = (cnt < WC) | hs;
  assign empty     = (cnt == '0);
  assign do_app    = app_en & room;

  always_comb begin
    base_acc = hs ? (acc << OUT_W) : acc;
    base_cnt = hs ? (eff - WC) : eff;
    ins = {app_val, {OUT_W{1'b0}}}
          << (WC - CNT_W'(app_len));
    ins = ins >> base_cnt;
    acc_n = base_acc;
    cnt_n = base_cnt;
    if (do_app) begin
      acc_n = base_acc | ins;
      cnt_n = base_cnt + CNT_W'(app_len);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      acc <= acc_n;
      cnt <= cnt_n;
    end
  end

endmodule

// File: rtl/jls_golomb_packer.sv
// JPEG-LS Golomb-Rice encoder with LIMIT/qbpp escape and bit packer.
// Optional counters: define JLS_GOLOMB_STATS_EN.
module jls_golomb_packer
  import jls_pkg::*;
#(
  parameter int MERR_W = 16,
  parameter int K_W    = 5,
  parameter int LIMIT  = 32,
  parameter int QBPP   = 8,
  parameter int OUT_W  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_type,
  input  logic [MERR_W-1:0]          in_merr,
  input  logic [K_W-1:0]             in_k,
  input  logic [5:0]                 in_limit_adj,
  input  logic [OUT_W-1:0]           in_raw_val,
  input  logic [$clog2(OUT_W+1)-1:0] in_raw_len,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_word,
  output logic                       out_last,
  output logic                       escape
`ifdef JLS_GOLOMB_STATS_EN
  ,
  output logic [31:0]                stat_symbols,
  output logic [31:0]                stat_escapes,
  output logic [31:0]                stat_bits
`endif
);

  localparam int LEN_W = $clog2(OUT_W + 1);
  localparam logic [MERR_W-1:0] ZMAX = MERR_W'(OUT_W);

  jls_state_e state;
  jls_state_e state_n;

  logic [MERR_W-1:0] zl;
  logic [OUT_W-1:0]  tail_val;
  logic [LEN_W-1:0]  tail_len;

  logic              is_gol;
  logic              is_raw;
  logic              is_fl;
  logic              acc_gol;
  logic              acc_raw;
  logic [MERR_W-1:0] u;
  int                thr;
  logic              g_esc;
  logic [MERR_W-1:0] g_zeros;
  logic [OUT_W-1:0]  g_tail;
  logic [LEN_W-1:0]  g_len;
  logic [MERR_W-1:0] z_step;

  logic              app_en;
  logic [OUT_W-1:0]  app_val;
  logic [LEN_W-1:0]  app_len;
  logic              pad;
  logic              room;
  logic              empty;

  assign in_ready = (state == S_IDLE);
  assign is_gol   = (in_type == T_GOLOMB);
  assign is_raw   = (in_type == T_RAW);
  assign is_fl    = (in_type == T_FLUSH);
  assign acc_gol  = in_ready & in_valid & is_gol;
  assign acc_raw  = in_ready & in_valid & is_raw;

  always_comb begin
    u       = in_merr >> in_k;
    thr     = jls_thr(LIMIT, QBPP, in_limit_adj);
    g_esc   = !(int'(u) < thr);
    g_zeros = g_esc ? MERR_W'(thr) : u;
    g_tail  = (OUT_W'(1) << in_k)
            | (OUT_W'(in_merr) & ~({OUT_W{1'b1}} << in_k));
    g_len   = LEN_W'(in_k) + LEN_W'(1);
    // Escape tail: '1' then (merr-1) in QBPP bits.
    if (g_esc) begin
      g_tail = (OUT_W'(1) << QBPP)
             | ((OUT_W'(in_merr) - OUT_W'(1))
                & ~({OUT_W{1'b1}} << QBPP));
      g_len  = LEN_W'(QBPP + 1);
    end
    z_step = (zl > ZMAX) ? ZMAX : zl;
  end

  always_comb begin
    state_n = state;
    app_en  = 1'b0;
    app_val = '0;
    app_len = '0;
    pad     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (in_valid) begin
          unique case (1'b1)
            is_gol:
              state_n = (g_zeros != '0) ? S_ZEROS : S_TAIL;
            is_raw:
              state_n = (in_raw_len != '0) ? S_TAIL : S_IDLE;
            is_fl:
              state_n = S_FLUSH;
            default: state_n = S_IDLE;
          endcase
        end
      end
      S_ZEROS: begin
        app_en  = room;
        app_len = LEN_W'(z_step);
        if (room && (zl == z_step))
          state_n = S_TAIL;
      end
      S_TAIL: begin
        app_en  = room;
        app_val = tail_val;
        app_len = tail_len;
        if (room)
          state_n = S_IDLE;
      end
      S_FLUSH: begin
        pad = 1'b1;
        if (empty || (out_valid && out_ready && out_last))
          state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zl       <= '0;
      tail_val <= '0;
      tail_len <= '0;
      escape   <= 1'b0;
    end else begin
      escape <= acc_gol & g_esc;
      if (acc_gol) begin
        zl       <= g_zeros;
        tail_val <= g_tail;
        tail_len <= g_len;
      end else if (acc_raw) begin
        zl       <= '0;
        tail_val <= in_raw_val;
        tail_len <= in_raw_len;
      end else if (state == S_ZEROS && room) begin
        zl <= zl - z_step;
      end
    end
  end

`ifdef JLS_GOLOMB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_symbols <= '0;
      stat_escapes <= '0;
      stat_bits    <= '0;
    end else begin
      if (acc_gol || acc_raw)
        stat_symbols <= stat_symbols + 32'd1;
      if (acc_gol && g_esc)
        stat_escapes <= stat_escapes + 32'd1;
      if (app_en)
        stat_bits <= stat_bits + 32'(app_len);
    end
  end
`endif

  jls_bit_accumulator #(
    .OUT_W (OUT_W),
    .LEN_W (LEN_W)
  ) u_acc (
    .clk       (clk),
    .reset     (reset),
    .app_en    (app_en),
    .app_val   (app_val),
    .app_len   (app_len),
    .pad       (pad),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_word  (out_word),
    .out_last  (out_last),
    .room      (room),
    .empty     (empty)
  );

endmodule
